// File: rtl/alu_flag_pkg.sv
// rtl/alu_flag_pkg.sv - shared types and branch-condition evaluation for alu_flag_sink
package alu_flag_pkg;
  localparam int N_DEF  = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [2:0] {AL, EQ, NE, LT, GE, LE, GT, NV} cond_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

  typedef struct packed {
    logic [N_DEF-1:0]  z;
    logic              we;
    logic [RW_DEF-1:0] rd;
  } wb_entry_t;

  function automatic logic cond_eval(input cond_e c, input logic z, input logic s);
    case (c)
      AL:      cond_eval = 1'b1;
      EQ:      cond_eval = z;
      NE:      cond_eval = !z;
      LT:      cond_eval = s;
      GE:      cond_eval = !s;
      LE:      cond_eval = z || s;
      GT:      cond_eval = !z && !s;
      default: cond_eval = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - generic 2-entry valid/ready skid buffer; output comes from the main entry only
module skid_buf
  import alu_flag_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state_q, state_d;
  T            main_q, skid_q;
  logic        acc, drn, load_main, load_skid, main_from_skid;

  assign in_ready  = rst_n && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid && in_ready;
  assign drn       = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && !drn) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (drn && !acc) begin
          state_d = EMPTY;
        end else if (acc && drn) begin
          load_main = 1'b1;
        end
      end
      TWO: begin
        // in_ready is low here, so the only event is a drain promoting the skid entry
        if (drn) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main)
        main_q <= in_data;
      else if (main_from_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_flag_sink.sv
// rtl/alu_flag_sink.sv - ALU result sink: skid-buffered writeback, flags register, branch queries
// Optional ALU_FLAG_FWD_EN forwards same-cycle flag writes to branch queries.
module alu_flag_sink
  import alu_flag_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_z,
  input  logic          in_zf,
  input  logic          in_sf,
  input  logic          in_setf,
  input  logic          in_we,
  input  logic [RW-1:0] in_rd,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [N-1:0]  wb_z,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic          flag_z,
  output logic          flag_s,
  input  logic          br_req,
  input  logic [2:0]    br_cond,
  output logic          br_valid,
  output logic          br_taken
);

  wb_entry_t in_entry, wb_entry;
  logic      acc, f_z, f_s;

  assign in_entry.z  = in_z;
  assign in_entry.we = in_we;
  assign in_entry.rd = in_rd;

  skid_buf #(.T(wb_entry_t)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(wb_valid),
    .out_ready(wb_ready),
    .out_data (wb_entry)
  );

  assign wb_z  = wb_entry.z;
  assign wb_we = wb_entry.we;
  assign wb_rd = wb_entry.rd;
  assign acc   = in_valid && in_ready;

`ifdef ALU_FLAG_FWD_EN
  assign f_z = (acc && in_setf) ? in_zf : flag_z;
  assign f_s = (acc && in_setf) ? in_sf : flag_s;
`else
  assign f_z = flag_z;
  assign f_s = flag_s;
`endif

  // Flags commit on accept, not on drain, so branches see them even under writeback stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z   <= 1'b0;
      flag_s   <= 1'b0;
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      if (acc && in_setf) begin
        flag_z <= in_zf;
        flag_s <= in_sf;
      end
      br_valid <= br_req;
      br_taken <= br_req ? cond_eval(cond_e'(br_cond), f_z, f_s) : 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_flag_sink.sv
// tb/tb_alu_flag_sink.sv - self-checking bench for alu_flag_sink with a writeback scoreboard
module tb_alu_flag_sink;
  import alu_flag_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_z = '0;
  logic        in_zf = 1'b0, in_sf = 1'b0, in_setf = 1'b0, in_we = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_z;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic        flag_z, flag_s;
  logic        br_req = 1'b0;
  logic [2:0]  br_cond = '0;
  logic        br_valid, br_taken;

  int          checks = 0;
  int          failures = 0;
  int          drained = 0;
  wb_entry_t   sb[$];
  wb_entry_t   exp_e;

  alu_flag_sink dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_zf(in_zf), .in_sf(in_sf),
    .in_setf(in_setf), .in_we(in_we), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_z(wb_z), .wb_we(wb_we), .wb_rd(wb_rd),
    .flag_z(flag_z), .flag_s(flag_s),
    .br_req(br_req), .br_cond(br_cond), .br_valid(br_valid), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  // Scoreboard: handshakes observed mid-cycle will complete on the next rising edge
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      checks++;
      drained++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got z=%h we=%b rd=%0d, required no entry", wb_z, wb_we, wb_rd);
      end else begin
        exp_e = sb.pop_front();
        if ({wb_z, wb_we, wb_rd} !== exp_e) begin
          failures++;
          $display("FAIL wb_entry got z=%h we=%b rd=%0d, required z=%h we=%b rd=%0d",
                   wb_z, wb_we, wb_rd, exp_e.z, exp_e.we, exp_e.rd);
        end
      end
    end
    if (rst_n && in_valid && in_ready) begin
      exp_e.z  = in_z;
      exp_e.we = in_we;
      exp_e.rd = in_rd;
      sb.push_back(exp_e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] z, input logic zf, input logic sf, input logic setf,
                      input logic we, input logic [4:0] rd);
    bit acc;
    bit done = 0;
    in_valid = 1'b1; in_z = z; in_zf = zf; in_sf = sf; in_setf = setf; in_we = we; in_rd = rd;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = in_ready;
      step();
      if (acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout z=%h not accepted within 50 cycles", z);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got %0d entries pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_z = 32'hdeadbeef; in_setf = 1'b1; in_zf = 1'b1;
    wb_ready = 1'b1; br_req = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b required 0", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got %b required 0", wb_valid); end
    checks++; if ({flag_z, flag_s} !== 2'b00) begin failures++; $display("FAIL reset_flags got %b%b required 00", flag_z, flag_s); end
    checks++; if (br_valid !== 1'b0) begin failures++; $display("FAIL reset_br_valid got %b required 0", br_valid); end
    checks++; if ({wb_z, wb_we, wb_rd} !== '0) begin failures++; $display("FAIL reset_wb_data got z=%h required 0", wb_z); end
    in_valid = 1'b0; in_setf = 1'b0; br_req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_pass_through();
    wb_ready = 1'b1;
    send(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL pass_wb_valid got %b required 1", wb_valid); end
    checks++; if (wb_z !== 32'h0) begin failures++; $display("FAIL pass_wb_z got %h required 00000000", wb_z); end
    checks++; if (flag_z !== 1'b1 || flag_s !== 1'b0) begin failures++; $display("FAIL pass_flags got z=%b s=%b required z=1 s=0", flag_z, flag_s); end
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL pass_wb_idle got %b required 0", wb_valid); end
  endtask

  task automatic test_backpressure();
    int base = drained;
    wb_ready = 1'b0;
    send(32'h1122_33ff, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
    send(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got %b required 0", in_ready); end
    in_valid = 1'b1; in_z = 32'hffff_fffe; in_we = 1'b1; in_rd = 5'd4; in_setf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_z !== 32'h1122_33ff || wb_rd !== 5'd1) begin
        failures++;
        $display("FAIL bp_hold got in_ready=%b wb_valid=%b z=%h rd=%0d required 0 1 112233ff 1",
                 in_ready, wb_valid, wb_z, wb_rd);
      end
    end
    wb_ready = 1'b1;
    send(32'hffff_fffe, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
    wait_empty();
    step();
    checks++; if (drained - base !== 3) begin failures++; $display("FAIL bp_count got %0d drained required 3", drained - base); end
  endtask

  task automatic test_back_to_back();
    int base = drained;
    wb_ready = 1'b1;
    in_valid = 1'b1; in_setf = 1'b0; in_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_z = 32'h0101_0101 * i;
      in_rd = 5'(i + 8);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got %b required 1 at beat %0d", in_ready, i); end
      step();
    end
    in_valid = 1'b0;
    wait_empty();
    step();
    checks++; if (drained - base !== 8) begin failures++; $display("FAIL b2b_count got %0d drained required 8", drained - base); end
  endtask

  task automatic test_conditions();
    logic [7:0] exp_taken = 8'b0010_1101;
    wb_ready = 1'b1;
    send(32'hffff_fffe, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7);
    br_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      br_cond = 3'(c);
      step();
      checks++;
      if (br_valid !== 1'b1 || br_taken !== exp_taken[c]) begin
        failures++;
        $display("FAIL cond_%0d got valid=%b taken=%b required valid=1 taken=%b", c, br_valid, br_taken, exp_taken[c]);
      end
    end
    br_req = 1'b0; br_cond = 3'(AL);
    step();
    checks++; if (br_valid !== 1'b0 || br_taken !== 1'b0) begin failures++; $display("FAIL cond_idle got valid=%b taken=%b required 0 0", br_valid, br_taken); end
    wait_empty();
  endtask

  task automatic test_hazard();
    logic exp_fwd;
`ifdef ALU_FLAG_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    wb_ready = 1'b1;
    in_valid = 1'b1; in_z = 32'h0; in_zf = 1'b1; in_sf = 1'b0; in_setf = 1'b1; in_we = 1'b0; in_rd = 5'd0;
    br_req = 1'b1; br_cond = 3'(EQ);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_in_ready got %b required 1", in_ready); end
    step();
    in_valid = 1'b0; in_setf = 1'b0;
    checks++; if (br_valid !== 1'b1 || br_taken !== exp_fwd) begin failures++; $display("FAIL hazard_eq got taken=%b required %b", br_taken, exp_fwd); end
    step();
    br_req = 1'b0;
    checks++; if (br_taken !== 1'b1 || flag_z !== 1'b1) begin failures++; $display("FAIL hazard_after got taken=%b flag_z=%b required 1 1", br_taken, flag_z); end
    wait_empty();
  endtask

  task automatic test_reset_mid();
    int base;
    wb_ready = 1'b0;
    send(32'haaaa_0001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
    send(32'haaaa_0002, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_two got in_ready=%b required 0", in_ready); end
    rst_n = 1'b0; in_valid = 1'b1; in_z = 32'haaaa_0003;
    step();
    sb.delete();
    checks++; if (wb_valid !== 1'b0 || wb_z !== 32'h0) begin failures++; $display("FAIL mid_reset got wb_valid=%b z=%h required 0 00000000", wb_valid, wb_z); end
    rst_n = 1'b1; in_valid = 1'b0; wb_ready = 1'b1;
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL mid_after got wb_valid=%b required 0", wb_valid); end
    base = drained;
    send(32'h5a5a_c3c3, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12);
    wait_empty();
    step();
    checks++; if (drained - base !== 1 || wb_valid !== 1'b0) begin failures++; $display("FAIL mid_new got %0d drained valid=%b required 1 0", drained - base, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_back_to_back();
    test_conditions();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
